// File: rtl/ddr_write_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_write_arbiter
//
// Purpose:
//   Two-requester write arbiter in front of a DDR RAM controller. A granted
//   write is latched into registered mem_addr/mem_data, and mem_wr_req is
//   held until the controller answers with mem_ack or a cycle timeout
//   expires. Simultaneous requests alternate using a round-robin pointer.
//   A requester must drop do_write before it can be granted again (rearm).
//
// Ports:
//   clk, rst                      sole clock, synchronous active-high reset
//   reqK_do_write                 level write request, held until reqK_ack
//   reqK_addr / reqK_data         write address / write word
//   reqK_ack                      one-cycle write-done pulse
//   reqK_is_writing               high while requester K's write is in flight
//   mem_wr_req                    write strobe to the controller
//   mem_addr / mem_data           registered address / data of current write
//   mem_ack                       one-cycle completion from the controller
//   mem_busy                      controller cannot accept a new write
//   err_timeout                   sticky flag, set when mem_ack never arrived
//   wr_count0 / wr_count1         completed-write counters
//
// Configuration:
//   ARB_WR_STATS_EN  when defined, wr_count0/1 count writes completed by
//                    mem_ack (saturating); otherwise they are tied to zero.
// ---------------------------------------------------------------------------
module ddr_write_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_do_write,
  input  logic              req1_do_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ack,
  output logic              req1_ack,
  output logic              req0_is_writing,
  output logic              req1_is_writing,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  input  logic              mem_busy,
  output logic              err_timeout,
  output logic [31:0]       wr_count0,
  output logic [31:0]       wr_count1
);

  // The wait counter is at least 10 bits wide and grows with TIMEOUT.
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW > 10) ? CNT_RAW : 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_e;

  state_e            state_q;
  logic              ptr_q;
  logic              owner_q;
  logic              rearm0_q;
  logic              rearm1_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              memWrReq_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memData_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              isWriting0_q;
  logic              isWriting1_q;
  logic              errTimeout_q;

  logic elig0;
  logic elig1;
  logic grantValid;
  logic grantSel;
  logic memDone;
  logic memTimeout;

  // Grant decision and completion conditions. The pointer only matters when
  // both requesters are eligible; a lone requester always wins.
  // The timeout fires on the TIMEOUT-th cycle in WAIT_MEM, so mem_wr_req is
  // high for exactly TIMEOUT cycles; a mem_ack on that same cycle wins.
  always_comb begin
    elig0      = req0_do_write & rearm0_q;
    elig1      = req1_do_write & rearm1_q;
    grantValid = (state_q == IDLE) && !mem_busy && (elig0 || elig1);
    if (elig0 && elig1) begin
      grantSel = ptr_q;
    end else begin
      grantSel = elig1;
    end
    memDone    = (state_q == WAIT_MEM) && mem_ack;
    memTimeout = (state_q == WAIT_MEM) && !mem_ack && (cnt_q == CNT_LAST);
  end

  // Arbiter FSM with registered outputs. Rearm is set whenever do_write is
  // seen low, and cleared on completion (the clear is written later so it
  // takes priority), which stops a still-held request from a second grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      rearm0_q     <= 1'b1;
      rearm1_q     <= 1'b1;
      cnt_q        <= '0;
      memWrReq_q   <= 1'b0;
      memAddr_q    <= '0;
      memData_q    <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      isWriting0_q <= 1'b0;
      isWriting1_q <= 1'b0;
      errTimeout_q <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      if (!req0_do_write) begin
        rearm0_q <= 1'b1;
      end
      if (!req1_do_write) begin
        rearm1_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (grantValid) begin
            state_q      <= WAIT_MEM;
            owner_q      <= grantSel;
            ptr_q        <= ~grantSel;
            cnt_q        <= '0;
            memWrReq_q   <= 1'b1;
            memAddr_q    <= grantSel ? req1_addr : req0_addr;
            memData_q    <= grantSel ? req1_data : req0_data;
            isWriting0_q <= ~grantSel;
            isWriting1_q <= grantSel;
          end
        end
        WAIT_MEM: begin
          if (memDone || memTimeout) begin
            state_q      <= IDLE;
            memWrReq_q   <= 1'b0;
            isWriting0_q <= 1'b0;
            isWriting1_q <= 1'b0;
            if (owner_q) begin
              ack1_q   <= 1'b1;
              rearm1_q <= 1'b0;
            end else begin
              ack0_q   <= 1'b1;
              rearm0_q <= 1'b0;
            end
            if (memTimeout) begin
              errTimeout_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_wr_req      = memWrReq_q;
  assign mem_addr        = memAddr_q;
  assign mem_data        = memData_q;
  assign req0_ack        = ack0_q;
  assign req1_ack        = ack1_q;
  assign req0_is_writing = isWriting0_q;
  assign req1_is_writing = isWriting1_q;
  assign err_timeout     = errTimeout_q;

`ifdef ARB_WR_STATS_EN
  logic [31:0] wrCount0_q;
  logic [31:0] wrCount1_q;

  // Count only writes the controller acknowledged; timeouts are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrCount0_q <= '0;
      wrCount1_q <= '0;
    end else if (memDone) begin
      if (!owner_q && (wrCount0_q != 32'hFFFF_FFFF)) begin
        wrCount0_q <= wrCount0_q + 32'd1;
      end
      if (owner_q && (wrCount1_q != 32'hFFFF_FFFF)) begin
        wrCount1_q <= wrCount1_q + 32'd1;
      end
    end
  end

  assign wr_count0 = wrCount0_q;
  assign wr_count1 = wrCount1_q;
`else
  assign wr_count0 = 32'd0;
  assign wr_count1 = 32'd0;
`endif

endmodule

// File: tb/tb_ddr_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_write_arbiter
//
// Self-checking bench for ddr_write_arbiter (TIMEOUT overridden to 15).
// Expected grants are queued when a request is raised and compared when
// mem_wr_req rises; single-requester writes come from a vector table and the
// multi-cycle corner cases are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_ddr_write_arbiter;

  localparam int ADDR_W  = 28;
  localparam int DATA_W  = 128;
  localparam int TIMEOUT = 15;

`ifdef ARB_WR_STATS_EN
  localparam logic [31:0] EXP_CNT1 = 32'd5;
`else
  localparam logic [31:0] EXP_CNT1 = 32'd0;
`endif

  logic              clk;
  logic              rst;
  logic              req0_do_write;
  logic              req1_do_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req0_data;
  logic [DATA_W-1:0] req1_data;
  logic              req0_ack;
  logic              req1_ack;
  logic              req0_is_writing;
  logic              req1_is_writing;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ack;
  logic              mem_busy;
  logic              err_timeout;
  logic [31:0]       wr_count0;
  logic [31:0]       wr_count1;

  ddr_write_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_do_write  (req0_do_write),
    .req1_do_write  (req1_do_write),
    .req0_addr      (req0_addr),
    .req1_addr      (req1_addr),
    .req0_data      (req0_data),
    .req1_data      (req1_data),
    .req0_ack       (req0_ack),
    .req1_ack       (req1_ack),
    .req0_is_writing(req0_is_writing),
    .req1_is_writing(req1_is_writing),
    .mem_wr_req     (mem_wr_req),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_ack        (mem_ack),
    .mem_busy       (mem_busy),
    .err_timeout    (err_timeout),
    .wr_count0      (wr_count0),
    .wr_count1      (wr_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit                who;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_t;

  typedef struct {
    bit                who;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                ackAfter;
    int                expHigh;
    bit                expErr;
  } vec_t;

  sb_t  sbQ[$];
  vec_t vecs[5];
  int   passCount  = 0;
  int   checkCount = 0;
  logic prevWr     = 1'b0;

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each rise of mem_wr_req must match the oldest expected grant.
  always @(negedge clk) begin
    if (mem_wr_req && !prevWr) begin
      if (sbQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL sb_unexpected_grant: grant at addr %0h with no expected entry", mem_addr);
      end else begin
        sb_t e;
        e = sbQ.pop_front();
        check("sb_addr", mem_addr, e.addr);
        check("sb_data", mem_data, e.data);
        check("sb_owner", {req1_is_writing, req0_is_writing}, e.who ? 2'b10 : 2'b01);
      end
    end
    prevWr = mem_wr_req;
  end

  task automatic raise(input bit who, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    sb_t e;
    e.who  = who;
    e.addr = addr;
    e.data = data;
    sbQ.push_back(e);
    if (who) begin
      req1_addr = addr;
      req1_data = data;
      req1_do_write = 1'b1;
    end else begin
      req0_addr = addr;
      req0_data = data;
      req0_do_write = 1'b1;
    end
  endtask

  task automatic drop(input int who);
    if (who == 1) req1_do_write = 1'b0;
    else req0_do_write = 1'b0;
  endtask

  // Plays the RAM controller: acks after ackAfter cycles of mem_wr_req
  // (0 = never) and returns on the tick where a requester ack is seen.
  task automatic serviceOne(input int ackAfter, output int highCycles, output int who);
    highCycles = 0;
    who = -1;
    for (int c = 0; c < 80 && who < 0; c++) begin
      tick();
      mem_ack = 1'b0;
      if (req0_ack || req1_ack) begin
        who = req1_ack ? 1 : 0;
      end else if (mem_wr_req) begin
        highCycles++;
        if (ackAfter != 0 && highCycles == ackAfter) mem_ack = 1'b1;
      end
    end
    check("svc_ack_seen", (who >= 0), 1'b1);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_wr_req"}, mem_wr_req, 1'b0);
    check({tag, "_addr"}, mem_addr, '0);
    check({tag, "_data"}, mem_data, '0);
    check({tag, "_acks"}, {req1_ack, req0_ack}, 2'b00);
    check({tag, "_writing"}, {req1_is_writing, req0_is_writing}, 2'b00);
    check({tag, "_err"}, err_timeout, 1'b0);
    check({tag, "_counts"}, {wr_count1, wr_count0}, 64'd0);
  endtask

  task automatic applyStimulus();
    int h;
    int w;
    int busyGrants;

    // Reset state.
    rst = 1'b1; mem_ack = 1'b0; mem_busy = 1'b0;
    req0_do_write = 1'b0; req1_do_write = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    tick(); tick();
    checkOutput("reset");
    rst = 1'b0;
    tick();

    // mem_ack while idle is ignored.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_acks", {req1_ack, req0_ack}, 2'b00);
    check("idle_ack_wr", mem_wr_req, 1'b0);

    // Table: single-requester writes; timeout vector is last (err is sticky).
    vecs[0] = '{1'b0, 28'h0000008, {8{16'hAAAA}}, 3, 3, 1'b0};
    vecs[1] = '{1'b1, 28'h0ABCDEF, {4{32'h1234_5678}}, 1, 1, 1'b0};
    vecs[2] = '{1'b0, 28'hFFFFFFF, {2{64'hDEAD_BEEF_0BAD_F00D}}, 5, 5, 1'b0};
    vecs[3] = '{1'b1, 28'h0000001, {8{16'h5555}}, 15, 15, 1'b0};
    vecs[4] = '{1'b0, 28'h0C0FFEE, {8{16'h0F0F}}, 0, 15, 1'b1};
    for (int i = 0; i < 5; i++) begin
      raise(vecs[i].who, vecs[i].addr, vecs[i].data);
      serviceOne(vecs[i].ackAfter, h, w);
      check("vec_ack_who", w, vecs[i].who);
      check("vec_high_cycles", h, vecs[i].expHigh);
      check("vec_err", err_timeout, vecs[i].expErr);
      check("vec_writing_low", {req1_is_writing, req0_is_writing}, 2'b00);
      drop(vecs[i].who);
      tick();
      check("vec_ack_pulse", {req1_ack, req0_ack}, 2'b00);
    end
    tick(); tick();
    check("err_sticky", err_timeout, 1'b1);
    rst = 1'b1;
    tick();
    checkOutput("reset2");
    rst = 1'b0;
    tick();

    // Both requesting after reset, re-requesting after rearm: 0,1,0,1.
    raise(1'b0, 28'h0000100, {8{16'h1000}});
    raise(1'b1, 28'h0000200, {8{16'h2000}});
    sbQ.push_back('{1'b0, 28'h0000100, {8{16'h1000}}});
    sbQ.push_back('{1'b1, 28'h0000200, {8{16'h2000}}});
    for (int k = 0; k < 4; k++) begin
      serviceOne(2, h, w);
      check("rr_order", w, k % 2);
      drop(w);
      tick();
      check("rr_ack_pulse", {req1_ack, req0_ack}, 2'b00);
      if (k < 2) begin
        if (w == 1) req1_do_write = 1'b1;
        else req0_do_write = 1'b1;
      end
    end

    // Pointer moves after a lone grant: req0 alone, then both -> req1 first.
    raise(1'b0, 28'h0000300, {8{16'h3000}});
    serviceOne(1, h, w);
    check("ptr_lone_who", w, 0);
    drop(0);
    tick();
    raise(1'b0, 28'h0000301, {8{16'h3001}});
    raise(1'b1, 28'h0000401, {8{16'h4001}});
    sbQ.delete(sbQ.size() - 2);
    sbQ.push_back('{1'b0, 28'h0000301, {8{16'h3001}}});
    serviceOne(2, h, w);
    check("ptr_both_first", w, 1);
    drop(1);
    serviceOne(2, h, w);
    check("ptr_both_second", w, 0);
    drop(0);
    tick();

    // do_write held two cycles past ack: no regrant until it drops and rises.
    raise(1'b0, 28'h0000500, {8{16'h5000}});
    serviceOne(2, h, w);
    check("hold_who", w, 0);
    tick();
    check("hold_no_regrant1", mem_wr_req, 1'b0);
    tick();
    check("hold_no_regrant2", mem_wr_req, 1'b0);
    drop(0);
    tick();
    check("hold_no_regrant3", mem_wr_req, 1'b0);
    raise(1'b0, 28'h0000501, {8{16'h5001}});
    serviceOne(1, h, w);
    check("hold_regrant_who", w, 0);
    drop(0);
    tick();

    // Requester address/data changes during WAIT_MEM do not leak through.
    raise(1'b1, 28'h0000600, {8{16'h6000}});
    tick();
    req1_addr = 28'h0FFFFFF;
    req1_data = {8{16'hFFFF}};
    tick();
    check("hold_addr_stable", mem_addr, 28'h0000600);
    check("hold_data_stable", mem_data, {8{16'h6000}});
    serviceOne(2, h, w);
    check("stable_who", w, 1);
    drop(1);
    tick();

    // mem_busy for 20 cycles: no grant, then grant the cycle after it falls.
    mem_busy = 1'b1;
    raise(1'b1, 28'h0000700, {8{16'h7000}});
    busyGrants = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_wr_req) busyGrants++;
    end
    check("busy_no_grant", busyGrants, 0);
    mem_busy = 1'b0;
    tick();
    check("busy_grant_next", mem_wr_req, 1'b1);
    serviceOne(1, h, w);
    check("busy_who", w, 1);
    drop(1);
    tick();

    // Reset mid-WAIT_MEM abandons the write; then 5 acked writes on req1.
    raise(1'b1, 28'h0000800, {8{16'h8000}});
    tick(); tick();
    check("midrst_in_flight", mem_wr_req, 1'b1);
    rst = 1'b1;
    req1_do_write = 1'b0;
    tick();
    checkOutput("midrst");
    tick();
    checkOutput("midrst2");
    rst = 1'b0;
    tick();
    check("midrst_no_ack", {req1_ack, req0_ack, mem_wr_req}, 3'b000);
    for (int n = 0; n < 5; n++) begin
      raise(1'b1, ADDR_W'(28'h0000900 + n), {8{16'h9000}});
      serviceOne(2, h, w);
      check("stats_who", w, 1);
      drop(1);
      tick();
    end
    check("wr_count1", wr_count1, EXP_CNT1);
    check("wr_count0", wr_count0, 32'd0);
  endtask

  initial begin
    applyStimulus();
    tick();
    check("sb_drained", sbQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Hard bound on run time so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete, %0d of %0d checks done", passCount, checkCount);
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/ddr_write_arbiter.md
DDR_WRITE_ARBITER -- requirements
Module: ddr_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, meaning write address width.
REQ-002 SHALL have parameter DATA_W, default 128, meaning write word width (8 x 16-bit pixels).
REQ-003 SHALL have parameter TIMEOUT, default 1023, meaning maximum cycles to wait for mem_ack.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports req0_do_write / req1_do_write  in  1 each  write request, level, held until acked.
REQ-007 SHALL have ports req0_addr / req1_addr  in  ADDR_W each  word address.
REQ-008 SHALL have ports req0_data / req1_data  in  DATA_W each  write word.
REQ-009 SHALL have ports req0_ack / req1_ack  out  1 each  one-cycle write-done pulse to the requester.
REQ-010 SHALL have ports req0_is_writing / req1_is_writing  out  1 each  high while that requester's write is in flight.
REQ-011 SHALL have port mem_wr_req  out  1  write strobe to the RAM controller, held until mem_ack.
REQ-012 SHALL have ports mem_addr / mem_data  out  ADDR_W / DATA_W  registered address/data, stable while mem_wr_req high.
REQ-013 SHALL have ports mem_ack  in  1  one-cycle completion pulse; mem_busy  in  1  controller cannot accept.
REQ-014 SHALL have port err_timeout  out  1  sticky flag set when mem_ack is not received within TIMEOUT.
REQ-015 SHALL have ports wr_count0 / wr_count1  out  32 each  completed-write counters (see Configuration).

Function
REQ-016 SHALL implement states IDLE and WAIT_MEM only.
REQ-017 In IDLE with mem_busy low, an eligible request SHALL be latched at cycle t, giving mem_wr_req, mem_addr, mem_data and reqK_is_writing high/valid at t+1, in state WAIT_MEM.
REQ-018 A request SHALL be eligible only when reqK_do_write is high and rearm_K is set; with mem_busy high, no grant occurs.
REQ-019 On simultaneous eligible requests, the grant SHALL go to the requester named by the round-robin pointer; after every grant the pointer SHALL point to the other requester.
REQ-020 A single eligible requester SHALL be granted regardless of the pointer, and the pointer SHALL still update.
REQ-021 In WAIT_MEM, mem_ack at cycle m SHALL yield at m+1: mem_wr_req low, reqK_is_writing low, reqK_ack high for exactly one cycle, state IDLE.
REQ-022 The earliest next grant SHALL be at m+1, with mem_wr_req high again at m+2.
REQ-023 On ack, rearm_K SHALL clear and SHALL set only when reqK_do_write is sampled low, so a requester's still-high do_write is never granted twice.
REQ-024 In WAIT_MEM, a 10-bit-or-wider counter SHALL count cycles; on reaching TIMEOUT without mem_ack it SHALL drop mem_wr_req, pulse reqK_ack, set err_timeout and return to IDLE.
REQ-025 mem_ack in the same cycle as timeout expiry SHALL count as success, with err_timeout not set.
REQ-026 mem_ack received in IDLE SHALL be ignored.
REQ-027 Requester address/data changes during WAIT_MEM SHALL NOT affect mem_addr/mem_data.

Reset
REQ-028 While rst is high, all outputs SHALL be 0, state SHALL be IDLE, the pointer SHALL be 0, rearm_0/1 SHALL be 1, the timeout counter SHALL be 0 and err_timeout SHALL clear.
REQ-029 Reset asserted during WAIT_MEM SHALL abandon the transaction with no ack issued; the first grant after reset goes to requester 0 when both request.

Configuration
REQ-030 With ARB_WR_STATS_EN defined, wr_count0/1 SHALL increment by 1 on each reqK_ack caused by mem_ack (not timeout), saturate at 0xFFFFFFFF and clear on rst.
REQ-031 Without ARB_WR_STATS_EN, wr_count0/1 SHALL be constant 0 with no counter logic synthesized; ports remain present.

Verification
REQ-032 Scenario: req0 addr 0x0000008, data 0x..AAAA, mem_ack 3 cycles after mem_wr_req -> mem_addr=0x0000008, req0_ack one pulse, req0_is_writing high 3 cycles.
REQ-033 Scenario: req0 and req1 both high after reset, each re-requesting after rearm -> grant order 0,1,0,1; mem_addr alternates accordingly.
REQ-034 Scenario: req0 holds do_write high 2 cycles after ack -> no second mem_wr_req until req0_do_write drops and rises again.
REQ-035 Scenario: TIMEOUT=15, mem_ack never -> mem_wr_req drops after 15 cycles, req0_ack pulses, err_timeout=1 until rst.
REQ-036 Scenario: mem_busy high while req1 is pending for 20 cycles -> no mem_wr_req; grant issued the cycle after mem_busy falls.
REQ-037 Scenario: rst pulsed mid-WAIT_MEM, then 5 acked writes on req1 with ARB_WR_STATS_EN -> all outputs 0 during rst, no ack, wr_count1=5 (0 without macro).
